// File: rtl/piano_pkg.sv
// Shared definitions for the piano datapath: note bit positions, sequencer
// FSM states and the default song length.
package piano_pkg;

  // Bit positions on the 8-bit note-enable line bus
  localparam int unsigned NOTE_C  = 0;
  localparam int unsigned NOTE_D  = 1;
  localparam int unsigned NOTE_E  = 2;
  localparam int unsigned NOTE_F  = 3;
  localparam int unsigned NOTE_G  = 4;
  localparam int unsigned NOTE_A  = 5;
  localparam int unsigned NOTE_B  = 6;
  localparam int unsigned NOTE_C2 = 7;

  // Number of ROM steps in the stock phrase
  localparam int unsigned SONG_LEN_DEFAULT = 9;

  typedef enum logic [1:0] {
    StIdle,
    StNote,
    StGap
  } seq_state_e;

  // One-hot line mask for a single note position
  function automatic logic [7:0] note_bit(input int unsigned pos);
    return 8'(1) << pos;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational chord table: step index in, note-enable line out.
// Swapping the tune only touches this file.
module song_rom
  import piano_pkg::*;
(
  input  logic [3:0] addr_i,
  output logic [7:0] data_o
);

  // F + A + C2 chord (0xA8)
  localparam logic [7:0] ChordFac = note_bit(NOTE_F) | note_bit(NOTE_A) | note_bit(NOTE_C2);

  // Chord lookup; unused entries are silent
  always_comb begin
    data_o = 8'h00;
    case (addr_i)
      4'd0:    data_o = ChordFac;
      4'd1:    data_o = note_bit(NOTE_C);
      4'd2:    data_o = note_bit(NOTE_D);
      4'd3:    data_o = note_bit(NOTE_C);
      4'd4:    data_o = note_bit(NOTE_F);
      4'd5:    data_o = note_bit(NOTE_A);
      4'd6:    data_o = note_bit(NOTE_B);
      4'd7:    data_o = note_bit(NOTE_A);
      4'd8:    data_o = ChordFac;
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/song_sequencer.sv
// Song player: steps through song_rom at a fixed tempo, emitting each chord
// for the note part of a beat and silence for the articulation gap.
// Restarts on a rising edge of the debounced play level; dropping play aborts.
module song_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 247500,
  parameter int unsigned GAP_CYCLES  = 12500,
  parameter int unsigned SONG_LEN    = SONG_LEN_DEFAULT,
  parameter bit          LOOP        = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  output logic [7:0] line,
  output logic       playing,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int unsigned CntW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CntW-1:0] NoteLast = CntW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [CntW-1:0] BeatLast = CntW'(BEAT_CYCLES - 1);
  localparam logic [3:0]      IdxLast  = 4'(SONG_LEN - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      line_q, line_d;
  logic            playing_q, playing_d;
  logic            done_q, done_d;
  logic            play_q;
  logic            start;
  logic            step_end;
  logic [7:0]      rom_data;

  assign start = play & ~play_q;

  // Look up the chord for the step we are about to enter so line is registered
  song_rom u_song_rom (
    .addr_i (idx_d),
    .data_o (rom_data)
  );

  // State register; play_q keeps sampling through reset so a switch held
  // across reset is not mistaken for a fresh press
  always_ff @(posedge clk) begin
    play_q <= play;
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      line_q    <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  // Next-state: beat timing, end-of-step sequencing, abort overrides all
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    step_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StNote;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StNote: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == NoteLast) begin
          if (GAP_CYCLES == 0) begin
            step_end = 1'b1;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == BeatLast) begin
          step_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step_end) begin
      cnt_d = '0;
      if (idx_q < IdxLast) begin
        idx_d   = idx_q + 4'd1;
        state_d = StNote;
      end else if (LOOP) begin
        idx_d   = '0;
        state_d = StNote;
      end else begin
        idx_d   = '0;
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    if ((state_q != StIdle) && !play) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Output decode from the upcoming state, registered on the next edge
  always_comb begin
    line_d    = (state_d == StNote) ? rom_data : 8'h00;
    playing_d = (state_d != StIdle);
  end

  assign line     = line_q;
  assign playing  = playing_q;
  assign step_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one-shot, looping and gapless instances
// driven from vector tables and short hand-written sequences.
module tb_song_sequencer;

  localparam int unsigned Beat = 8;
  localparam int unsigned Gap  = 2;
  localparam int unsigned Len  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       play_a, play_l, play_n;
  logic [7:0] line_a, line_l, line_n;
  logic       playing_a, playing_l, playing_n;
  logic [3:0] step_a, step_l, step_n;
  logic       done_a, done_l, done_n;

  song_sequencer #(.BEAT_CYCLES(Beat), .GAP_CYCLES(Gap), .SONG_LEN(Len), .LOOP(1'b0)) dut_a (
    .clk(clk), .reset(reset), .play(play_a), .line(line_a), .playing(playing_a),
    .step_idx(step_a), .done(done_a)
  );

  song_sequencer #(.BEAT_CYCLES(Beat), .GAP_CYCLES(Gap), .SONG_LEN(Len), .LOOP(1'b1)) dut_l (
    .clk(clk), .reset(reset), .play(play_l), .line(line_l), .playing(playing_l),
    .step_idx(step_l), .done(done_l)
  );

  song_sequencer #(.BEAT_CYCLES(Beat), .GAP_CYCLES(0), .SONG_LEN(Len), .LOOP(1'b0)) dut_n (
    .clk(clk), .reset(reset), .play(play_n), .line(line_n), .playing(playing_n),
    .step_idx(step_n), .done(done_n)
  );

  typedef struct {
    logic       play;
    logic [7:0] line;
    logic       playing;
    logic [3:0] step;
    logic       done;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] rom_ref [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] l, input logic p,
                       input logic [3:0] s, input logic d, input logic [7:0] el,
                       input logic ep, input logic [3:0] es, input logic ed);
    n_checks++;
    if (l !== el || p !== ep || s !== es || d !== ed) begin
      n_fail++;
      $display("FAIL %s: got line=%02h playing=%0b step=%0d done=%0b, want line=%02h playing=%0b step=%0d done=%0b",
               name, l, p, s, d, el, ep, es, ed);
    end
  endtask

  // Expected line k cycles after the start edge
  function automatic logic [7:0] exp_line(input int k, input int gap);
    if ((k % Beat) < (Beat - gap)) return rom_ref[(k / Beat) % Len];
    return 8'h00;
  endfunction

  initial begin
    vec_t v;
    rom_ref = '{8'hA8, 8'h01, 8'h02, 8'h01, 8'h08, 8'h20, 8'h40, 8'h20,
                8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Full one-shot song table: 72 playing cycles, done pulse, then stays idle
    for (int k = 0; k < 72; k++) begin
      v = '{play: 1'b1, line: exp_line(k, Gap), playing: 1'b1, step: 4'((k / Beat) % Len),
            done: 1'b0};
      vecs.push_back(v);
    end
    v = '{play: 1'b1, line: 8'h00, playing: 1'b0, step: 4'd0, done: 1'b1};
    vecs.push_back(v);
    v = '{play: 1'b1, line: 8'h00, playing: 1'b0, step: 4'd0, done: 1'b0};
    vecs.push_back(v);
    vecs.push_back(v);

    // Reset with play held high
    reset  = 1'b1;
    play_a = 1'b1;
    play_l = 1'b0;
    play_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_play_no_start", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    end
    play_a = 1'b0;
    tick();
    check("idle_low", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);

    // Full song from vector table
    for (int i = 0; i < vecs.size(); i++) begin
      play_a = vecs[i].play;
      tick();
      check($sformatf("song_vec%0d", i), line_a, playing_a, step_a, done_a,
            vecs[i].line, vecs[i].playing, vecs[i].step, vecs[i].done);
    end
    play_a = 1'b0;
    tick();

    // Abort during step 3, NOTE cycle 2, then restart
    play_a = 1'b1;
    tick();
    check("abort_start", line_a, playing_a, step_a, done_a, 8'hA8, 1'b1, 4'd0, 1'b0);
    repeat (26) tick();
    check("abort_pre", line_a, playing_a, step_a, done_a, 8'h01, 1'b1, 4'd3, 1'b0);
    play_a = 1'b0;
    tick();
    check("abort_edge", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    check("abort_no_done", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    play_a = 1'b1;
    tick();
    check("abort_restart", line_a, playing_a, step_a, done_a, 8'hA8, 1'b1, 4'd0, 1'b0);

    // Abort on the final GAP cycle of step 8
    repeat (71) tick();
    check("last_gap", line_a, playing_a, step_a, done_a, 8'h00, 1'b1, 4'd8, 1'b0);
    play_a = 1'b0;
    tick();
    check("abort_vs_end", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    tick();
    check("abort_vs_end_after", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);

    // Looping instance: wraps to step 0 with no extra gap, never done
    play_l = 1'b1;
    for (int k = 0; k < 90; k++) begin
      tick();
      check($sformatf("loop_k%0d", k), line_l, playing_l, step_l, done_l,
            exp_line(k, Gap), 1'b1, 4'((k / Beat) % Len), 1'b0);
    end
    play_l = 1'b0;
    tick();
    check("loop_stop", line_l, playing_l, step_l, done_l, 8'h00, 1'b0, 4'd0, 1'b0);

    // Gapless instance: every step holds its chord for all 8 cycles
    play_n = 1'b1;
    for (int k = 0; k < 72; k++) begin
      tick();
      check($sformatf("nogap_k%0d", k), line_n, playing_n, step_n, done_n,
            rom_ref[k / Beat], 1'b1, 4'(k / Beat), 1'b0);
    end
    tick();
    check("nogap_done", line_n, playing_n, step_n, done_n, 8'h00, 1'b0, 4'd0, 1'b1);
    play_n = 1'b0;
    tick();
    check("nogap_idle", line_n, playing_n, step_n, done_n, 8'h00, 1'b0, 4'd0, 1'b0);

    // Reset mid-song
    play_a = 1'b1;
    tick();
    repeat (10) tick();
    check("mid_song", line_a, playing_a, step_a, done_a, 8'h01, 1'b1, 4'd1, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_reset", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", line_a, playing_a, step_a, done_a, 8'h00, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
